// File: rtl/exec_stage.sv
// Multi-cycle execute stage: decodes one instruction at a time against an internal 8x8 register
// file and presents each result to a downstream bank through a setup / ld-pulse / hold handshake.
module exec_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  resultULA,
    output logic [2:0]  rDest,
    output logic        ld,
    output logic        zero,
    output logic        illegal
);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StWbSetup,
        StWbPulse,
        StWbHold
    } state_e;

    localparam logic [3:0] OpAdd = 4'h0;
    localparam logic [3:0] OpSub = 4'h1;
    localparam logic [3:0] OpAnd = 4'h2;
    localparam logic [3:0] OpOr  = 4'h3;
    localparam logic [3:0] OpXor = 4'h4;
    localparam logic [3:0] OpNot = 4'h5;
    localparam logic [3:0] OpShl = 4'h6;
    localparam logic [3:0] OpShr = 4'h7;
    localparam logic [3:0] OpLdi = 4'h8;
    localparam logic [3:0] OpMul = 4'h9;
    localparam logic [3:0] OpNop = 4'hA;

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  result_q, result_d;
    logic [2:0]  rdest_q, rdest_d;
    logic        ld_q, ld_d;
    logic        zero_q, zero_d;
    logic        illegal_q, illegal_d;
    logic [7:0]  rf_q [8];
    logic [7:0]  rf_d [8];

    logic [3:0]  opcode;
    logic [2:0]  rd, rs, rt;
    logic [7:0]  imm;
    logic [7:0]  alu_res;
    logic [7:0]  mul_step;

    assign opcode = instr_q[15:12];
    assign rd     = instr_q[11:9];
    assign rs     = instr_q[8:6];
    assign rt     = instr_q[5:3];
    assign imm    = instr_q[7:0];

    // One shift-add step: op_a walks left, op_b walks right, low 8 bits kept.
    assign mul_step = acc_q + (op_b_q[0] ? op_a_q : 8'h00);

    always_comb begin
        alu_res = 8'h00;
        case (opcode)
            OpAdd:   alu_res = op_a_q + op_b_q;
            OpSub:   alu_res = op_a_q - op_b_q;
            OpAnd:   alu_res = op_a_q & op_b_q;
            OpOr:    alu_res = op_a_q | op_b_q;
            OpXor:   alu_res = op_a_q ^ op_b_q;
            OpNot:   alu_res = ~op_a_q;
            OpShl:   alu_res = op_a_q << op_b_q[2:0];
            OpShr:   alu_res = op_a_q >> op_b_q[2:0];
            OpLdi:   alu_res = imm;
            OpMul:   alu_res = mul_step;
            default: alu_res = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        rdest_d   = rdest_q;
        zero_d    = zero_q;
        illegal_d = 1'b0;
        rf_d      = rf_q;

        case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = StDecode;
                    // Flag raised here so it is visible for exactly the DECODE cycle.
                    illegal_d = (instr[15:12] > OpNop);
                end
            end
            StDecode: begin
                if (opcode >= OpNop) begin
                    state_d = StIdle;
                end else begin
                    op_a_d  = rf_q[rs];
                    op_b_d  = rf_q[rt];
                    acc_d   = 8'h00;
                    cnt_d   = 3'd0;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (opcode == OpMul) begin
                    acc_d  = mul_step;
                    op_a_d = op_a_q << 1;
                    op_b_d = op_b_q >> 1;
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        result_d = mul_step;
                        rdest_d  = rd;
                        state_d  = StWbSetup;
                    end
                end else begin
                    result_d = alu_res;
                    rdest_d  = rd;
                    state_d  = StWbSetup;
                end
            end
            StWbSetup: state_d = StWbPulse;
            StWbPulse: state_d = StWbHold;
            StWbHold: begin
                rf_d[rdest_q] = result_q;
                zero_d        = (result_q == 8'h00);
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Registered so the strobe comes straight off a flop.
        ld_d = (state_d == StWbPulse);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            instr_q   <= 16'h0000;
            op_a_q    <= 8'h00;
            op_b_q    <= 8'h00;
            acc_q     <= 8'h00;
            cnt_q     <= 3'd0;
            result_q  <= 8'h00;
            rdest_q   <= 3'd0;
            ld_q      <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            rdest_q   <= rdest_d;
            ld_q      <= ld_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            rf_q      <= rf_d;
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign resultULA   = result_q;
    assign rDest       = rdest_q;
    assign ld          = ld_q;
    assign zero        = zero_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_exec_stage.sv
// Randomised self-checking bench for exec_stage against a register-file-level reference model.
// Latencies are counted in falling edges after the accepting rising edge (k = 1 is DECODE).
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  resultULA;
    logic [2:0]  rDest;
    logic        ld;
    logic        zero;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_rf [8];
    logic       m_zero;

    exec_stage dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .resultULA   (resultULA),
        .rDest       (rDest),
        .ld          (ld),
        .zero        (zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] s, input logic [2:0] t);
        return {op, d, s, t, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] v);
        return {4'h8, d, 1'b0, v};
    endfunction

    // Reference: what the instruction should produce, from the opcode table.
    function automatic logic [7:0] model_eval(input logic [15:0] ins, output bit writes);
        logic [7:0] a, b;
        int p;
        a = m_rf[ins[8:6]];
        b = m_rf[ins[5:3]];
        writes = (ins[15:12] <= 4'h9);
        case (ins[15:12])
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~a;
            4'h6: return a << b[2:0];
            4'h7: return a >> b[2:0];
            4'h8: return ins[7:0];
            4'h9: begin p = int'(a) * int'(b); return 8'(p % 256); end
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_commit(input logic [15:0] ins, input logic [7:0] r);
        m_rf[ins[11:9]] = r;
        m_zero = (r == 8'h00);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_zero = 1'b0;
    endfunction

    // Issues one instruction and records what the outputs did; comparisons live in the callers.
    task automatic issue(input logic [15:0] ins, output int ld_k, output int ld_cnt,
                         output logic [7:0] res, output logic [2:0] rdst, output bit stable,
                         output int ill_cnt, output int rdy_k);
        logic [7:0] rh [64];
        logic [2:0] dh [64];
        int w;
        ld_k = -1; ld_cnt = 0; res = 8'h00; rdst = 3'd0; stable = 1'b0; ill_cnt = 0; rdy_k = -1;
        @(negedge clk);
        w = 0;
        while (!instr_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (k == 1) instr_valid = 1'b0;
            rh[k] = resultULA;
            dh[k] = rDest;
            if (illegal) ill_cnt++;
            if (ld) begin
                ld_cnt++;
                if (ld_k < 0) begin
                    ld_k = k;
                    res  = resultULA;
                    rdst = rDest;
                end
            end
            if (instr_ready) begin
                rdy_k = k;
                break;
            end
        end
        if (ld_k > 1 && rdy_k > ld_k)
            stable = (rh[ld_k-1] == rh[ld_k]) && (rh[ld_k+1] == rh[ld_k]) &&
                     (dh[ld_k-1] == dh[ld_k]) && (dh[ld_k+1] == dh[ld_k]);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0000;
        #12;
        checks++; if (resultULA !== 8'h00) begin errors++;
            $display("FAIL reset_result: got %h want 00", resultULA); end
        checks++; if (rDest !== 3'd0) begin errors++;
            $display("FAIL reset_rdest: got %0d want 0", rDest); end
        checks++; if ({ld, zero, illegal} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got ld/zero/illegal=%b want 000", {ld, zero, illegal}); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_add();
        int ld_k, ld_cnt, ill, rdy, total;
        logic [7:0] res;
        logic [2:0] rdst;
        bit st;
        total = 0;
        issue(ldi(3'd1, 8'h05), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(ldi(3'd1, 8'h05), 8'h05); total += ld_cnt;
        issue(ldi(3'd2, 8'h03), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(ldi(3'd2, 8'h03), 8'h03); total += ld_cnt;
        issue(enc(4'h0, 3'd3, 3'd1, 3'd2), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(enc(4'h0, 3'd3, 3'd1, 3'd2), 8'h08); total += ld_cnt;
        checks++; if (total != 3) begin errors++;
            $display("FAIL add_ld_pulses: got %0d want 3", total); end
        checks++; if (res !== 8'h08 || rdst !== 3'd3) begin errors++;
            $display("FAIL add_result: got %h/r%0d want 08/r3", res, rdst); end
        checks++; if (ld_k != 4 || rdy != 6) begin errors++;
            $display("FAIL add_latency: got ld@%0d ready@%0d want ld@4 ready@6", ld_k, rdy); end
        checks++; if (zero !== 1'b0) begin errors++;
            $display("FAIL add_zero: got %b want 0", zero); end
        checks++; if (!st) begin errors++;
            $display("FAIL add_stable: got unstable want stable around ld"); end
    endtask

    task automatic test_wrap();
        int ld_k, ld_cnt, ill, rdy;
        logic [7:0] res;
        logic [2:0] rdst;
        bit st;
        issue(ldi(3'd1, 8'hFF), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(ldi(3'd1, 8'hFF), 8'hFF);
        issue(ldi(3'd2, 8'h01), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(ldi(3'd2, 8'h01), 8'h01);
        issue(enc(4'h0, 3'd4, 3'd1, 3'd2), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(enc(4'h0, 3'd4, 3'd1, 3'd2), 8'h00);
        checks++; if (res !== 8'h00 || rdst !== 3'd4) begin errors++;
            $display("FAIL wrap_add: got %h/r%0d want 00/r4", res, rdst); end
        checks++; if (zero !== 1'b1) begin errors++;
            $display("FAIL wrap_zero: got %b want 1", zero); end
        issue(enc(4'h1, 3'd5, 3'd2, 3'd1), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(enc(4'h1, 3'd5, 3'd2, 3'd1), 8'h02);
        checks++; if (res !== 8'h02 || rdst !== 3'd5 || zero !== 1'b0) begin errors++;
            $display("FAIL wrap_sub: got %h/r%0d z%b want 02/r5 z0", res, rdst, zero); end
    endtask

    task automatic test_mul();
        int ld_k, ld_cnt, ill, rdy;
        logic [7:0] res;
        logic [2:0] rdst;
        bit st;
        issue(ldi(3'd1, 8'h0C), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(ldi(3'd1, 8'h0C), 8'h0C);
        issue(ldi(3'd2, 8'h0B), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(ldi(3'd2, 8'h0B), 8'h0B);
        issue(enc(4'h9, 3'd6, 3'd1, 3'd2), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(enc(4'h9, 3'd6, 3'd1, 3'd2), 8'h84);
        checks++; if (res !== 8'h84 || rdst !== 3'd6) begin errors++;
            $display("FAIL mul_result: got %h/r%0d want 84/r6", res, rdst); end
        checks++; if (ld_k != 11 || ld_cnt != 1) begin errors++;
            $display("FAIL mul_latency: got ld@%0d x%0d want ld@11 x1", ld_k, ld_cnt); end
        checks++; if (rdy != 13) begin errors++;
            $display("FAIL mul_ready: got first ready@%0d want 13", rdy); end
    endtask

    task automatic test_illegal();
        int ld_k, ld_cnt, ill, rdy;
        logic [7:0] res;
        logic [2:0] rdst;
        logic       z0;
        bit st;
        z0 = m_zero;
        issue(16'hC2D8, ld_k, ld_cnt, res, rdst, st, ill, rdy);
        checks++; if (ill != 1 || ld_cnt != 0 || rdy != 2) begin errors++;
            $display("FAIL illegal_op: got ill=%0d ld=%0d rdy@%0d want 1 0 2", ill, ld_cnt, rdy); end
        issue(16'hA2D8, ld_k, ld_cnt, res, rdst, st, ill, rdy);
        checks++; if (ill != 0 || ld_cnt != 0 || rdy != 2) begin errors++;
            $display("FAIL nop_op: got ill=%0d ld=%0d rdy@%0d want 0 0 2", ill, ld_cnt, rdy); end
        checks++; if (zero !== z0) begin errors++;
            $display("FAIL nop_zero: got %b want %b", zero, z0); end
        issue(enc(4'h3, 3'd7, 3'd1, 3'd6), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        checks++; if (res !== (m_rf[1] | m_rf[6])) begin errors++;
            $display("FAIL nop_regs: got %h want %h", res, m_rf[1] | m_rf[6]); end
        model_commit(enc(4'h3, 3'd7, 3'd1, 3'd6), m_rf[1] | m_rf[6]);
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [3];
        logic [7:0]  rh [48];
        logic [2:0]  dh [48];
        logic        lh [48];
        logic [7:0]  exp_r [3];
        int idx, accepts, lds, acc_k0, acc_k1, pulse;
        bit advance, stable, vals_ok;
        prog[0] = ldi(3'd1, 8'h07);
        prog[1] = enc(4'h0, 3'd2, 3'd1, 3'd1);
        prog[2] = enc(4'h0, 3'd3, 3'd2, 3'd1);
        exp_r[0] = 8'd7; exp_r[1] = 8'd14; exp_r[2] = 8'd21;
        idx = 1; accepts = 0; lds = 0; advance = 1'b0; acc_k0 = -1; acc_k1 = -1;
        @(negedge clk);
        instr = prog[0];
        instr_valid = 1'b1;
        for (int k = 0; k < 48; k++) begin
            rh[k] = resultULA; dh[k] = rDest; lh[k] = ld;
            if (ld) lds++;
            if (advance) begin
                if (idx < 3) begin instr = prog[idx]; idx++; end
                else instr_valid = 1'b0;
                advance = 1'b0;
            end
            if (instr_valid && instr_ready) begin
                if (accepts == 0) acc_k0 = k;
                if (accepts == 1) acc_k1 = k;
                accepts++;
                advance = 1'b1;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        stable = 1'b1; vals_ok = 1'b1; pulse = 0;
        for (int k = 1; k < 47; k++) begin
            if (lh[k]) begin
                if (rh[k-1] != rh[k] || rh[k+1] != rh[k] || dh[k-1] != dh[k] || dh[k+1] != dh[k])
                    stable = 1'b0;
                if (pulse < 3 && (rh[k] != exp_r[pulse] || dh[k] != 3'(pulse + 1)))
                    vals_ok = 1'b0;
                pulse++;
            end
        end
        checks++; if (accepts != 3 || lds != 3) begin errors++;
            $display("FAIL b2b_counts: got acc=%0d ld=%0d want 3 3", accepts, lds); end
        checks++; if (acc_k1 - acc_k0 != 6) begin errors++;
            $display("FAIL b2b_spacing: got %0d want 6", acc_k1 - acc_k0); end
        checks++; if (!stable) begin errors++;
            $display("FAIL b2b_stable: got unstable want stable around each ld"); end
        checks++; if (!vals_ok) begin errors++;
            $display("FAIL b2b_values: got wrong result/rdest want 07/r1 0e/r2 15/r3"); end
        for (int i = 0; i < 3; i++) model_commit(prog[i], exp_r[i]);
    endtask

    task automatic test_random();
        int ld_k, ld_cnt, ill, rdy, exp_ld, exp_rdy, exp_ill;
        logic [7:0]  res, exp_res;
        logic [2:0]  rdst;
        logic [11:0] f;
        logic [3:0]  op;
        logic [15:0] ins;
        bit st, wr, ok;
        for (int n = 0; n < 60; n++) begin
            op  = 4'($urandom_range(0, 15));
            f   = 12'($urandom());
            ins = {op, f};
            exp_res = model_eval(ins, wr);
            exp_ld  = wr ? ((op == 4'h9) ? 11 : 4) : -1;
            exp_rdy = wr ? exp_ld + 2 : 2;
            exp_ill = (op > 4'hA) ? 1 : 0;
            issue(ins, ld_k, ld_cnt, res, rdst, st, ill, rdy);
            if (wr) model_commit(ins, exp_res);
            ok = (ld_k == exp_ld) && (rdy == exp_rdy) && (ill == exp_ill) &&
                 (ld_cnt == (wr ? 1 : 0)) && (zero === m_zero);
            if (wr) ok = ok && (res === exp_res) && (rdst === ins[11:9]) && st;
            checks++; if (!ok) begin errors++;
                $display("FAIL rand_%0d ins=%h: got res=%h rd=%0d ld@%0d x%0d rdy@%0d ill=%0d z=%b st=%0b want res=%h rd=%0d ld@%0d rdy@%0d ill=%0d z=%b",
                         n, ins, res, rdst, ld_k, ld_cnt, rdy, ill, zero, st,
                         exp_res, ins[11:9], exp_ld, exp_rdy, exp_ill, m_zero);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ld_k, ld_cnt, ill, rdy;
        logic [7:0] res;
        logic [2:0] rdst;
        bit st;
        // Abort during WB_PULSE.
        @(negedge clk);
        instr = enc(4'h3, 3'd7, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) instr_valid = 1'b0;
        end
        checks++; if (ld !== 1'b1) begin errors++;
            $display("FAIL pulse_before_abort: got ld=%b want 1", ld); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ld !== 1'b0 || resultULA !== 8'h00 || rDest !== 3'd0) begin errors++;
            $display("FAIL abort_pulse: got ld=%b res=%h rd=%0d want 0 00 0", ld, resultULA, rDest); end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        // Abort during the 4th MUL EXEC cycle.
        issue(ldi(3'd1, 8'h0C), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(ldi(3'd1, 8'h0C), 8'h0C);
        issue(ldi(3'd2, 8'h0B), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(ldi(3'd2, 8'h0B), 8'h0B);
        @(negedge clk);
        instr = enc(4'h9, 3'd6, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) instr_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        checks++; if ({ld, zero, illegal} !== 3'b000 || resultULA !== 8'h00 || rDest !== 3'd0)
        begin errors++;
            $display("FAIL abort_mul: got ld/z/ill=%b res=%h rd=%0d want 000 00 0",
                     {ld, zero, illegal}, resultULA, rDest); end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++;
            $display("FAIL abort_ready: got %b want 1", instr_ready); end
        issue(enc(4'h3, 3'd5, 3'd6, 3'd6), ld_k, ld_cnt, res, rdst, st, ill, rdy);
        model_commit(enc(4'h3, 3'd5, 3'd6, 3'd6), 8'h00);
        checks++; if (res !== 8'h00 || rdst !== 3'd5 || zero !== 1'b1) begin errors++;
            $display("FAIL abort_dest: got R6=%h rd=%0d z=%b want 00 5 1", res, rdst, zero); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
